caliptra_ss_lc_pwr_seq: RTL

CALIPTRA_SS_LC_PWR_SEQ -- requirements
Module: caliptra_ss_lc_pwr_seq

---
 rtl/caliptra_ss_lc_pwr_seq.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/caliptra_ss_lc_pwr_seq.sv
// Power-up / reset sequencer for the LC controller, plus the lc_tx clock-bypass handshake.
// state | meaning: IDLE no power, LC held in reset | DELAY settle before init | INIT init requested
//       | READY LC up | RESET LC reset pulse | ERROR init timed out, waiting for reset request
module caliptra_ss_lc_pwr_seq #(
    parameter int INIT_TIMEOUT = 4096,
    parameter int DELAY_W      = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               pwrgood_i,
    input  logic               rst_req_i,
    input  logic [DELAY_W-1:0] init_delay_i,
    input  logic [7:0]         rst_len_i,
    output logic               lc_init_o,
    input  logic               lc_done_i,
    output logic               lc_rst_no,
    input  logic [3:0]         clk_byp_req_i,
    input  logic [3:0]         byp_ack_dly_i,
    output logic [3:0]         clk_byp_ack_o,
    output logic               ready_o,
    output logic               timeout_err_o
);

    localparam logic [3:0] BYP_ON  = 4'b0101;
    localparam logic [3:0] BYP_OFF = 4'b1010;
    localparam int TO_W   = (INIT_TIMEOUT > 1) ? $clog2(INIT_TIMEOUT) : 1;
    localparam int CNT_W0 = (DELAY_W > TO_W) ? DELAY_W : TO_W;
    localparam int CNT_W  = (CNT_W0 > 8) ? CNT_W0 : 8;
    localparam logic [CNT_W-1:0] TO_TC   = CNT_W'(INIT_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        DELAY = 3'd1,
        INIT  = 3'd2,
        READY = 3'd3,
        RESET = 3'd4,
        ERROR = 3'd5
    } state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d, cnt_inc;
    logic [DELAY_W-1:0] dly_q, dly_d;
    logic [7:0]         len_q, len_d, len_tc;
    logic [3:0]         bcnt_q, bcnt_d;
    logic               lc_init_q, lc_init_d;
    logic               lc_rst_n_q, lc_rst_n_d;
    logic               ready_q, ready_d;
    logic               err_q, err_d;
    logic [3:0]         ack_q, ack_d;

    // A zero length still produces a one-cycle reset pulse.
    assign len_tc  = (len_q == 8'd0) ? 8'd0 : len_q - 8'd1;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_inc;
        dly_d   = dly_q;
        len_d   = len_q;
        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (pwrgood_i) begin
                    state_d = DELAY;
                    dly_d   = init_delay_i;
                end
            end
            DELAY: begin
                if (rst_req_i) begin
                    state_d = RESET;
                    len_d   = rst_len_i;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_W'(dly_q)) begin
                    state_d = INIT;
                    cnt_d   = '0;
                end
            end
            INIT: begin
                if (rst_req_i) begin
                    state_d = RESET;
                    len_d   = rst_len_i;
                    cnt_d   = '0;
                end else if (lc_done_i) begin
                    state_d = READY;
                end else if (cnt_q == TO_TC) begin
                    state_d = ERROR;
                end
            end
            READY, ERROR: begin
                if (rst_req_i) begin
                    state_d = RESET;
                    len_d   = rst_len_i;
                    cnt_d   = '0;
                end
            end
            RESET: begin
                if (cnt_q == CNT_W'(len_tc)) begin
                    state_d = DELAY;
                    dly_d   = init_delay_i;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
        // Loss of power overrides every other transition.
        if (!pwrgood_i) begin
            state_d = IDLE;
            cnt_d   = '0;
        end

        lc_init_d  = (state_d == INIT) || (state_d == READY);
        lc_rst_n_d = (state_d != IDLE) && (state_d != RESET);
        ready_d    = (state_d == READY);
        err_d      = (state_d == ERROR);

        if ((state_d == IDLE) || (state_d == RESET) || (clk_byp_req_i != BYP_ON)) begin
            bcnt_d = 4'd0;
            ack_d  = BYP_OFF;
        end else if (bcnt_q >= byp_ack_dly_i) begin
            bcnt_d = bcnt_q;
            ack_d  = BYP_ON;
        end else begin
            bcnt_d = bcnt_q + 4'd1;
            ack_d  = BYP_OFF;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            dly_q      <= '0;
            len_q      <= '0;
            bcnt_q     <= 4'd0;
            lc_init_q  <= 1'b0;
            lc_rst_n_q <= 1'b0;
            ready_q    <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= BYP_OFF;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dly_q      <= dly_d;
            len_q      <= len_d;
            bcnt_q     <= bcnt_d;
            lc_init_q  <= lc_init_d;
            lc_rst_n_q <= lc_rst_n_d;
            ready_q    <= ready_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
        end
    end

    assign lc_init_o     = lc_init_q;
    assign lc_rst_no     = lc_rst_n_q;
    assign ready_o       = ready_q;
    assign timeout_err_o = err_q;
    assign clk_byp_ack_o = ack_q;

endmodule
